data_mem_arbiter: RTL and testbench

//  Shares the single-port MIPS data memory (combinational read, write on posedge) between
//  two requesters: port A (CPU load/store unit) and port B (debug/program loader).

---
 rtl/data_mem_arbiter_pkg.sv | 18 +
 rtl/data_mem_arbiter_rr_arb2.sv | 24 ++
 rtl/data_mem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_arbiter_pkg.sv
// Shared types for the data memory arbiter: FSM states and requester ids.
package data_mem_arbiter_pkg;

  typedef enum logic {
    StIdle   = 1'b0,
    StAccess = 1'b1
  } state_e;

  typedef enum logic {
    PortA = 1'b0,
    PortB = 1'b1
  } port_e;

  function automatic port_e other_port(input port_e p);
    return (p == PortA) ? PortB : PortA;
  endfunction

endpackage

// File: rtl/data_mem_arbiter_rr_arb2.sv
// Combinational two-way grant: round-robin on last winner, or fixed priority to port A.
module data_mem_arbiter_rr_arb2
  import data_mem_arbiter_pkg::*;
#(
  parameter bit PRIO_FIXED = 1'b0
) (
  input  logic  i_elig_a,
  input  logic  i_elig_b,
  input  port_e i_last_winner,
  output logic  o_valid,
  output port_e o_winner
);

  always_comb begin
    o_valid  = i_elig_a | i_elig_b;
    o_winner = PortA;
    if (i_elig_a && i_elig_b) begin
      o_winner = PRIO_FIXED ? PortA : other_port(i_last_winner);
    end else if (i_elig_b) begin
      o_winner = PortB;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-requester arbiter in front of a single-port data memory: one access every two cycles,
// registered per-port read data, and an out-of-range guard on the word address.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int unsigned N_BIT      = 31,
  parameter int unsigned MEM_SIZE   = 2047,
  parameter bit          PRIO_FIXED = 1'b0
) (
  input  logic             in_clk,
  input  logic             in_rst_n,
  input  logic             in_a_req,
  input  logic             in_a_we,
  input  logic [N_BIT:0]   in_a_addr,
  input  logic [N_BIT:0]   in_a_wdata,
  output logic             out_a_ack,
  output logic [N_BIT:0]   out_a_rdata,
  output logic             out_a_err,
  input  logic             in_b_req,
  input  logic             in_b_we,
  input  logic [N_BIT:0]   in_b_addr,
  input  logic [N_BIT:0]   in_b_wdata,
  output logic             out_b_ack,
  output logic [N_BIT:0]   out_b_rdata,
  output logic             out_b_err,
  output logic             out_mem_we,
  output logic [N_BIT:0]   out_mem_addr,
  output logic [N_BIT:0]   out_mem_wdata,
  input  logic [N_BIT:0]   in_mem_rdata,
  output logic             out_busy
);

  localparam logic [N_BIT:0] MemLast = (N_BIT + 1)'(MEM_SIZE);

  state_e         r_state;
  state_e         w_state_nxt;
  port_e          r_winner;
  port_e          r_last_winner;
  logic           r_we;
  logic [N_BIT:0] r_addr;
  logic [N_BIT:0] r_wdata;

  logic           r_a_ack;
  logic           r_a_err;
  logic [N_BIT:0] r_a_rdata;
  logic           r_b_ack;
  logic           r_b_err;
  logic [N_BIT:0] r_b_rdata;

  logic           w_elig_a;
  logic           w_elig_b;
  logic           w_grant_valid;
  port_e          w_grant;
  logic           w_latch;
  logic           w_complete;
  logic           w_in_range;
  logic [N_BIT:0] w_rd_value;
  logic           w_done_a;
  logic           w_done_b;

  // A port is masked during its own ack cycle so a still-high req is not taken as a new one.
  assign w_elig_a = in_a_req & ~r_a_ack;
  assign w_elig_b = in_b_req & ~r_b_ack;

  data_mem_arbiter_rr_arb2 #(
    .PRIO_FIXED (PRIO_FIXED)
  ) u_arb (
    .i_elig_a      (w_elig_a),
    .i_elig_b      (w_elig_b),
    .i_last_winner (r_last_winner),
    .o_valid       (w_grant_valid),
    .o_winner      (w_grant)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_complete  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_grant_valid) begin
          w_latch     = 1'b1;
          w_state_nxt = StAccess;
        end
      end
      StAccess: begin
        w_complete  = 1'b1;
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_winner      <= PortA;
      r_last_winner <= PortB;
      r_we          <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
    end else if (w_latch) begin
      r_winner <= w_grant;
      if (w_grant == PortA) begin
        r_we    <= in_a_we;
        r_addr  <= in_a_addr;
        r_wdata <= in_a_wdata;
      end else begin
        r_we    <= in_b_we;
        r_addr  <= in_b_addr;
        r_wdata <= in_b_wdata;
      end
    end else if (w_complete) begin
      r_last_winner <= r_winner;
    end
  end

  assign w_in_range = (r_addr <= MemLast);
  // Writes and rejected reads both return zero so stale memory data never leaks out.
  assign w_rd_value = (r_we | ~w_in_range) ? '0 : in_mem_rdata;
  assign w_done_a   = w_complete & (r_winner == PortA);
  assign w_done_b   = w_complete & (r_winner == PortB);

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_a_ack   <= 1'b0;
      r_a_err   <= 1'b0;
      r_a_rdata <= '0;
    end else begin
      r_a_ack <= w_done_a;
      r_a_err <= w_done_a & ~w_in_range;
      if (w_done_a) begin
        r_a_rdata <= w_rd_value;
      end
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_b_ack   <= 1'b0;
      r_b_err   <= 1'b0;
      r_b_rdata <= '0;
    end else begin
      r_b_ack <= w_done_b;
      r_b_err <= w_done_b & ~w_in_range;
      if (w_done_b) begin
        r_b_rdata <= w_rd_value;
      end
    end
  end

  assign out_busy      = (r_state == StAccess);
  assign out_mem_we    = out_busy & r_we & w_in_range;
  assign out_mem_addr  = r_addr;
  assign out_mem_wdata = r_wdata;

  assign out_a_ack   = r_a_ack;
  assign out_a_err   = r_a_err;
  assign out_a_rdata = r_a_rdata;
  assign out_b_ack   = r_b_ack;
  assign out_b_err   = r_b_err;
  assign out_b_rdata = r_b_rdata;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: a round-robin and a fixed-priority instance, each with its own memory,
// checked cycle by cycle against a transaction-level model plus directed literal expectations.
module tb_data_mem_arbiter;

  localparam int unsigned MemSize = 2047;

  logic clk;
  logic rst_n;

  logic [1:0]       a_req, a_we, b_req, b_we;
  logic [1:0]       a_ack, a_err, b_ack, b_err, mem_we, busy;
  logic [1:0][31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic [1:0][31:0] a_rdata, b_rdata, mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem0 [4096];
  logic [31:0] mem1 [4096];

  int n_tests = 0;
  int n_fail  = 0;
  int we_cnt [2] = '{0, 0};

  // Model state, index 0 = round-robin instance, 1 = fixed-priority instance.
  bit          m_busy [2];
  bit          m_win  [2];
  bit          m_we   [2];
  bit          m_last [2];
  bit          m_ack_a [2];
  bit          m_ack_b [2];
  bit          m_err_a [2];
  bit          m_err_b [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic [31:0] m_rd_a  [2];
  logic [31:0] m_rd_b  [2];
  logic [31:0] gmem [2][4096];

  data_mem_arbiter #(.N_BIT(31), .MEM_SIZE(2047), .PRIO_FIXED(1'b0)) dut_rr (
    .in_clk(clk), .in_rst_n(rst_n),
    .in_a_req(a_req[0]), .in_a_we(a_we[0]), .in_a_addr(a_addr[0]), .in_a_wdata(a_wdata[0]),
    .out_a_ack(a_ack[0]), .out_a_rdata(a_rdata[0]), .out_a_err(a_err[0]),
    .in_b_req(b_req[0]), .in_b_we(b_we[0]), .in_b_addr(b_addr[0]), .in_b_wdata(b_wdata[0]),
    .out_b_ack(b_ack[0]), .out_b_rdata(b_rdata[0]), .out_b_err(b_err[0]),
    .out_mem_we(mem_we[0]), .out_mem_addr(mem_addr[0]), .out_mem_wdata(mem_wdata[0]),
    .in_mem_rdata(mem_rdata[0]), .out_busy(busy[0])
  );

  data_mem_arbiter #(.N_BIT(31), .MEM_SIZE(2047), .PRIO_FIXED(1'b1)) dut_fx (
    .in_clk(clk), .in_rst_n(rst_n),
    .in_a_req(a_req[1]), .in_a_we(a_we[1]), .in_a_addr(a_addr[1]), .in_a_wdata(a_wdata[1]),
    .out_a_ack(a_ack[1]), .out_a_rdata(a_rdata[1]), .out_a_err(a_err[1]),
    .in_b_req(b_req[1]), .in_b_we(b_we[1]), .in_b_addr(b_addr[1]), .in_b_wdata(b_wdata[1]),
    .out_b_ack(b_ack[1]), .out_b_rdata(b_rdata[1]), .out_b_err(b_err[1]),
    .out_mem_we(mem_we[1]), .out_mem_addr(mem_addr[1]), .out_mem_wdata(mem_wdata[1]),
    .in_mem_rdata(mem_rdata[1]), .out_busy(busy[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem0[i] = 32'hA5A5_0000 | i;
      mem1[i] = 32'hA5A5_0000 | i;
      gmem[0][i] = 32'hA5A5_0000 | i;
      gmem[1][i] = 32'hA5A5_0000 | i;
    end
  end

  assign mem_rdata[0] = mem0[mem_addr[0][11:0]];
  assign mem_rdata[1] = mem1[mem_addr[1][11:0]];

  always @(posedge clk) begin
    if (mem_we[0]) mem0[mem_addr[0][11:0]] <= mem_wdata[0];
    if (mem_we[1]) mem1[mem_addr[1][11:0]] <= mem_wdata[1];
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mem_we[d]) we_cnt[d]++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction model: an access is granted in an idle cycle and completes on the next edge.
  always @(posedge clk or negedge rst_n) begin
    bit          ea, eb, inr;
    logic [31:0] rd;
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_busy[d] = 0; m_win[d] = 0; m_we[d] = 0; m_last[d] = 1;
        m_ack_a[d] = 0; m_ack_b[d] = 0; m_err_a[d] = 0; m_err_b[d] = 0;
        m_addr[d] = 0; m_wdata[d] = 0; m_rd_a[d] = 0; m_rd_b[d] = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (m_busy[d]) begin
          inr = (m_addr[d] <= MemSize);
          if (m_we[d] && inr) gmem[d][m_addr[d][11:0]] = m_wdata[d];
          rd = (m_we[d] || !inr) ? 32'h0 : gmem[d][m_addr[d][11:0]];
          m_ack_a[d] = !m_win[d];
          m_ack_b[d] = m_win[d];
          m_err_a[d] = !m_win[d] && !inr;
          m_err_b[d] = m_win[d] && !inr;
          if (!m_win[d]) m_rd_a[d] = rd;
          else           m_rd_b[d] = rd;
          m_last[d] = m_win[d];
          m_busy[d] = 0;
        end else begin
          ea = a_req[d] && !m_ack_a[d];
          eb = b_req[d] && !m_ack_b[d];
          m_ack_a[d] = 0; m_ack_b[d] = 0; m_err_a[d] = 0; m_err_b[d] = 0;
          if (ea || eb) begin
            if (ea && eb) m_win[d] = (d == 1) ? 1'b0 : !m_last[d];
            else          m_win[d] = eb;
            m_we[d]    = m_win[d] ? b_we[d]    : a_we[d];
            m_addr[d]  = m_win[d] ? b_addr[d]  : a_addr[d];
            m_wdata[d] = m_win[d] ? b_wdata[d] : a_wdata[d];
            m_busy[d]  = 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    bit exp_we;
    for (int d = 0; d < 2; d++) begin
      exp_we = m_busy[d] && m_we[d] && (m_addr[d] <= MemSize);
      chk($sformatf("cmp%0d a_ack", d), a_ack[d], m_ack_a[d]);
      chk($sformatf("cmp%0d b_ack", d), b_ack[d], m_ack_b[d]);
      chk($sformatf("cmp%0d a_err", d), a_err[d], m_err_a[d]);
      chk($sformatf("cmp%0d b_err", d), b_err[d], m_err_b[d]);
      chk($sformatf("cmp%0d a_rdata", d), a_rdata[d], m_rd_a[d]);
      chk($sformatf("cmp%0d b_rdata", d), b_rdata[d], m_rd_b[d]);
      chk($sformatf("cmp%0d busy", d), busy[d], m_busy[d]);
      chk($sformatf("cmp%0d mem_we", d), mem_we[d], exp_we);
      if (exp_we) begin
        chk($sformatf("cmp%0d mem_addr", d), mem_addr[d], m_addr[d]);
        chk($sformatf("cmp%0d mem_wdata", d), mem_wdata[d], m_wdata[d]);
      end
    end
  end

  // Issues one access from an idle start, returns edges-to-ack and the memory write count.
  task automatic do_access(input int d, input bit pb, input bit we, input logic [31:0] addr,
                           input logic [31:0] wd, output int lat, output logic [31:0] rd,
                           output logic er, output int nwe);
    int w0;
    bit got;
    w0 = we_cnt[d]; lat = 0; got = 0; rd = '0; er = 1'b0;
    if (!pb) begin a_req[d] = 1; a_we[d] = we; a_addr[d] = addr; a_wdata[d] = wd; end
    else     begin b_req[d] = 1; b_we[d] = we; b_addr[d] = addr; b_wdata[d] = wd; end
    while (!got && lat < 20) begin
      @(posedge clk); #1; lat++;
      if (!pb && a_ack[d]) begin got = 1; rd = a_rdata[d]; er = a_err[d]; end
      if (pb && b_ack[d])  begin got = 1; rd = b_rdata[d]; er = b_err[d]; end
    end
    chk("ack_seen", got, 1);
    if (!pb) a_req[d] = 0; else b_req[d] = 0;
    @(posedge clk); #1;
    nwe = we_cnt[d] - w0;
  endtask

  // After a solo A access, both ports raise req together; exp_a_first says who must win.
  task automatic tie_test(input int d, input bit exp_a_first);
    int lat, nwe;
    logic [31:0] rd;
    logic er;
    do_access(d, 0, 0, 32'd20, 32'h0, lat, rd, er, nwe);
    chk("tie_pre_rdata", rd, 32'hA5A5_0014);
    a_req[d] = 1; a_we[d] = 0; a_addr[d] = 32'd21;
    b_req[d] = 1; b_we[d] = 0; b_addr[d] = 32'd22;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      chk($sformatf("tie%0d a_ack c%0d", d, c), a_ack[d],
          (c == 2 && exp_a_first) || (c == 4 && !exp_a_first));
      chk($sformatf("tie%0d b_ack c%0d", d, c), b_ack[d],
          (c == 2 && !exp_a_first) || (c == 4 && exp_a_first));
      if (c == 2) begin
        if (exp_a_first) a_req[d] = 0; else b_req[d] = 0;
      end
    end
    a_req[d] = 0; b_req[d] = 0;
    chk("tie_a_rdata", a_rdata[d], 32'hA5A5_0015);
    chk("tie_b_rdata", b_rdata[d], 32'hA5A5_0016);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nwe;
    logic [31:0] rd;
    logic er;

    rst_n = 1'b0;
    a_req = '0; a_we = '0; b_req = '0; b_we = '0;
    a_addr = '0; a_wdata = '0; b_addr = '0; b_wdata = '0;

    // Reset held with random stimulus: everything stays zero.
    repeat (10) begin
      @(posedge clk); #1;
      a_req = 2'($urandom); a_we = 2'($urandom); b_req = 2'($urandom); b_we = 2'($urandom);
      for (int d = 0; d < 2; d++) begin
        a_addr[d] = $urandom; a_wdata[d] = $urandom;
        b_addr[d] = $urandom; b_wdata[d] = $urandom;
      end
      #2;
      for (int d = 0; d < 2; d++) begin
        chk("rst_outputs", {a_ack[d], a_err[d], b_ack[d], b_err[d], mem_we[d], busy[d]}, 0);
        chk("rst_rdata", a_rdata[d] | b_rdata[d] | mem_addr[d] | mem_wdata[d], 0);
      end
    end
    a_req = '0; a_we = '0; b_req = '0; b_we = '0;
    a_addr = '0; a_wdata = '0; b_addr = '0; b_wdata = '0;
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Round-robin contention straight after reset: A,B,A,B.
    a_req[0] = 1; a_we[0] = 0; a_addr[0] = 32'd10;
    b_req[0] = 1; b_we[0] = 0; b_addr[0] = 32'd11;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      chk($sformatf("rr a_ack c%0d", c), a_ack[0], (c == 2 || c == 6));
      chk($sformatf("rr b_ack c%0d", c), b_ack[0], (c == 4 || c == 8));
      if (c == 2) chk("rr a_rdata", a_rdata[0], 32'hA5A5_000A);
      if (c == 4) chk("rr b_rdata", b_rdata[0], 32'hA5A5_000B);
      if (c == 6) a_req[0] = 0;
    end
    b_req[0] = 0;
    @(posedge clk); #1;

    // A write then read back.
    do_access(0, 0, 1, 32'd5, 32'hDEAD_BEEF, lat, rd, er, nwe);
    chk("wr5 latency", lat, 2);
    chk("wr5 mem_we cycles", nwe, 1);
    chk("wr5 err", er, 0);
    chk("wr5 rdata", rd, 0);
    do_access(0, 0, 0, 32'd5, 32'h0, lat, rd, er, nwe);
    chk("rd5 latency", lat, 2);
    chk("rd5 rdata", rd, 32'hDEAD_BEEF);
    chk("rd5 err", er, 0);
    chk("rd5 mem_we cycles", nwe, 0);

    // Out-of-range from B.
    do_access(0, 1, 1, 32'd2048, 32'h0000_1234, lat, rd, er, nwe);
    chk("wr2048 err", er, 1);
    chk("wr2048 mem_we cycles", nwe, 0);
    do_access(0, 1, 0, 32'd2048, 32'h0, lat, rd, er, nwe);
    chk("rd2048 rdata", rd, 0);
    chk("rd2048 err", er, 1);
    chk("mem2047 untouched", mem0[2047], 32'hA5A5_07FF);

    // Reset in the middle of an A write to address 7.
    a_req[0] = 1; a_we[0] = 1; a_addr[0] = 32'd7; a_wdata[0] = 32'h7777_7777;
    @(posedge clk); #1;
    chk("abort mem_we before", mem_we[0], 1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort mem_we after", mem_we[0], 0);
    chk("abort busy after", busy[0], 0);
    a_req[0] = 0; a_we[0] = 0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("abort no ack", a_ack[0], 0);
    end
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    do_access(0, 0, 0, 32'd7, 32'h0, lat, rd, er, nwe);
    chk("abort mem7 kept", rd, 32'hA5A5_0007);
    chk("abort rd7 err", er, 0);

    // Tie after an A win: fixed priority still picks A, round-robin picks B.
    tie_test(1, 1'b1);
    tie_test(0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
